clk_down_timer: RTL
===================

CLK_DOWN_TIMER -- requirements
Module: clk_down_timer

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of the count, reload value and out.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 load  input  1  in IDLE, capture load_val into the reload register and into out.
REQ-005 load_val  input  WIDTH  reload value N.
REQ-006 start  input  1  in IDLE, begin countdown.
REQ-007 enable  input  1  count qualifier; low pauses counting in RUN.
REQ-008 clr  input  1  synchronous abort to IDLE.
REQ-009 periodic  input  1  mode select, sampled on accepted start (1 = auto-reload, 0 = one-shot).
REQ-010 done_ack  input  1  acknowledges done.
REQ-011 out  output  WIDTH  current count.
REQ-012 busy  output  1  high while in RUN.
REQ-013 done  output  1  level, high in DONE until acknowledged.
REQ-014 tc  output  1  one-cycle terminal-count pulse.

Function
REQ-015 FSM states: IDLE, RUN, DONE; all outputs registered.
REQ-016 Tick: enable high in RUN (prescaler qualified per REQ-030).
REQ-017 IDLE: load applies REQ-004; start with reload != 0 -> RUN next edge, latch periodic.
REQ-018 IDLE: start with reload == 0 -> DONE; tc pulses once; no counting.
REQ-019 load and start same cycle in IDLE: load_val captured, countdown starts from load_val.
REQ-020 RUN: each tick, out decrements by 1, mod 2^WIDTH, no other wrap.
REQ-021 RUN: tick with out == 1, one-shot -> out = 0, state DONE, tc = 1 for one cycle.
REQ-022 RUN: tick with out == 1, periodic -> out = reload value, remain RUN, tc = 1 for one cycle.
REQ-023 Latency: continuous enable, no prescale: done rises exactly N cycles after busy rises; periodic tc period = N cycles.
REQ-024 DONE: done held; done_ack -> IDLE next edge, out stays 0; load/start ignored in DONE.
REQ-025 load and start outside IDLE are ignored; reload register unchanged.
REQ-026 clr: any state -> IDLE next edge; out = 0; busy, done, tc = 0; reload register retained; clr wins over every other input.

Reset
REQ-027 reset asserted: immediately IDLE, out = 0, reload register = 0, busy = 0, done = 0, tc = 0, prescaler = 0, independent of clk.
REQ-028 reset deassertion mid-countdown: block resumes in IDLE; no tc or done pulse produced.

Configuration
REQ-029 Macro CLK_DOWN_TIMER_PRESCALE_EN: when defined, adds input prescale (4 bits) and internal prescaler counter.
REQ-030 Defined: tick occurs once per (prescale+1) enable-high cycles in RUN; prescaler cleared on accepted start, clr, reset, and on every generated tick; prescale sampled at start.
REQ-031 Undefined: no prescale port; tick = enable in RUN; timing per REQ-023.

Verification
REQ-032 load_val = 5, load, start, enable = 1, one-shot -> busy 1; out 5,4,3,2,1,0; done and tc rise 5 cycles after busy; done_ack -> IDLE.
REQ-033 load_val = 3, periodic = 1 -> out 3,2,1,3,2,1...; tc every 3 cycles; done stays 0; clr -> IDLE, out = 0.
REQ-034 load_val = 4, enable low 2 cycles mid-run -> out holds 2 cycles; done delayed 2 cycles (6 after busy).
REQ-035 load_val = 0, start -> DONE next edge, single tc pulse, out = 0.
REQ-036 reset pulsed at out = 2 during RUN -> out = 0, busy = 0 without clock edge; no tc after release.
REQ-037 Macro defined, prescale = 2, load_val = 2 -> decrements every 3 cycles; done 6 cycles after busy.

Source files
------------

// File: rtl/clk_down_timer.sv
// Loadable down-counter with one-shot / auto-reload modes, done handshake and terminal-count pulse.
// Optional prescaler on the count tick is enabled by defining CLK_DOWN_TIMER_PRESCALE_EN.
module clk_down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             enable,
    input  logic             clr,
    input  logic             periodic,
    input  logic             done_ack,
`ifdef CLK_DOWN_TIMER_PRESCALE_EN
    input  logic [3:0]       prescale,
`endif
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] reloadReg;
    logic             periodicReg;
    logic             tick;
    logic [WIDTH-1:0] startVal;

    // A load in the same cycle as start takes priority over the stored reload value
    assign startVal = load ? load_val : reloadReg;

`ifdef CLK_DOWN_TIMER_PRESCALE_EN
    logic [3:0] prescaleReg;
    logic [3:0] preCount;

    assign tick = (state == RUN) && enable && (preCount == prescaleReg);
`else
    assign tick = (state == RUN) && enable;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            out         <= '0;
            reloadReg   <= '0;
            periodicReg <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            tc          <= 1'b0;
`ifdef CLK_DOWN_TIMER_PRESCALE_EN
            prescaleReg <= '0;
            preCount    <= '0;
`endif
        end else begin
            tc <= 1'b0;
            if (clr) begin
                state <= IDLE;
                out   <= '0;
                busy  <= 1'b0;
                done  <= 1'b0;
`ifdef CLK_DOWN_TIMER_PRESCALE_EN
                preCount <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (load) begin
                            reloadReg <= load_val;
                            out       <= load_val;
                        end
                        if (start) begin
                            periodicReg <= periodic;
`ifdef CLK_DOWN_TIMER_PRESCALE_EN
                            prescaleReg <= prescale;
                            preCount    <= '0;
`endif
                            // A zero count finishes immediately without entering RUN
                            if (startVal != '0) begin
                                state <= RUN;
                                busy  <= 1'b1;
                                out   <= startVal;
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                                tc    <= 1'b1;
                                out   <= '0;
                            end
                        end
                    end
                    RUN: begin
`ifdef CLK_DOWN_TIMER_PRESCALE_EN
                        if (enable) begin
                            preCount <= tick ? 4'd0 : preCount + 4'd1;
                        end
`endif
                        if (tick) begin
                            if (out == WIDTH'(1)) begin
                                tc <= 1'b1;
                                if (periodicReg) begin
                                    out <= reloadReg;
                                end else begin
                                    out   <= '0;
                                    state <= DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end else begin
                                out <= out - WIDTH'(1);
                            end
                        end
                    end
                    DONE: begin
                        if (done_ack) begin
                            state <= IDLE;
                            done  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
